// File: rtl/jtsdram_multichk.sv
// Multi-bank SDRAM read checker. Each bank sweeps its whole address range through the
// rd/ack/rdy handshake and compares the returned data with an address-derived reference.
module jtsdram_multichk #(
    parameter int              NB   = 4,
    parameter int              AW   = 22,
    parameter int              DW   = 16,
    parameter int              CW   = 8,
    parameter int              GAP  = 16,
    parameter logic [DW-1:0]   SEED = 16'h5A5A
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               mode_rnd,
    input  logic               slow,
    input  logic               LVBL,
    output logic [NB-1:0]      ba_rd,
    output logic [NB*AW-1:0]   ba_addr,
    input  logic [NB-1:0]      ba_ack,
    input  logic [NB-1:0]      ba_rdy,
    input  logic [DW-1:0]      data_read,
    output logic               busy,
    output logic               done,
    output logic               bad,
    output logic [NB-1:0]      ba_bad,
    output logic [NB*CW-1:0]   err_cnt,
    output logic [AW-1:0]      first_addr,
    output logic [1:0]         first_ba,
    output logic [DW-1:0]      first_data,
    output logic [DW-1:0]      first_ref,
    output logic               proto_err
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_GAP  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t          st_q  [NB];
    logic [AW-1:0]   cnt_q [NB];
    logic [15:0]     gap_q [NB];
    logic [CW-1:0]   err_q [NB];
    logic [NB-1:0]   rd_q;
    logic [NB-1:0]   bad_q;
    logic            mode_q;
    logic            slow_q;
    logic            first_vld_q;
    logic            proto_q;
    logic            done_q;
    logic [AW-1:0]   first_addr_q;
    logic [1:0]      first_ba_q;
    logic [DW-1:0]   first_data_q;
    logic [DW-1:0]   first_ref_q;

    logic [AW-1:0]   addr_s [NB];
    logic [DW-1:0]   ref_s  [NB];
    logic [NB-1:0]   busy_s;
    logic [NB-1:0]   fin_s;
    logic [NB-1:0]   rdy_ok_s;
    logic [NB-1:0]   rdy_bad_s;
    logic [NB-1:0]   ack_bad_s;
    logic [NB-1:0]   mis_s;
    logic            proto_s;
    logic            start_ok_s;
    int              n_rdy_s;

    function automatic logic [AW-1:0] bitrev_f(input logic [AW-1:0] v);
        logic [AW-1:0] r;
        for (int i = 0; i < AW; i++) begin
            r[i] = v[AW-1-i];
        end
        return r;
    endfunction

    function automatic logic [DW-1:0] ref_f(input logic [AW-1:0] a, input int b);
        return (DW'(a) ^ SEED) + DW'(b);
    endfunction

    // Per-bank address/reference generation and handshake legality decode
    always_comb begin
        n_rdy_s = 0;
        for (int b = 0; b < NB; b++) begin
            addr_s[b]    = mode_q ? bitrev_f(cnt_q[b]) : cnt_q[b];
            ref_s[b]     = ref_f(addr_s[b], b);
            busy_s[b]    = (st_q[b] == S_REQ) || (st_q[b] == S_WAIT) || (st_q[b] == S_GAP);
            fin_s[b]     = (st_q[b] == S_DONE);
            rdy_ok_s[b]  = ba_rdy[b] && ((st_q[b] == S_WAIT) || ((st_q[b] == S_REQ) && ba_ack[b]));
            rdy_bad_s[b] = ba_rdy[b] && !rdy_ok_s[b];
            ack_bad_s[b] = ba_ack[b] && (st_q[b] != S_REQ);
            n_rdy_s      = n_rdy_s + (ba_rdy[b] ? 1 : 0);
        end
        proto_s    = (n_rdy_s > 1) || (|rdy_bad_s) || (|ack_bad_s);
        start_ok_s = start && !(|busy_s);
        // A protocol violation still advances the handshake but never counts as a mismatch
        for (int b = 0; b < NB; b++) begin
            mis_s[b] = rdy_ok_s[b] && !proto_s && (data_read != ref_s[b]);
        end
    end

    // Bank FSMs, error bookkeeping and completion flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q         <= '0;
            bad_q        <= '0;
            mode_q       <= 1'b0;
            slow_q       <= 1'b0;
            first_vld_q  <= 1'b0;
            proto_q      <= 1'b0;
            done_q       <= 1'b0;
            first_addr_q <= '0;
            first_ba_q   <= 2'd0;
            first_data_q <= '0;
            first_ref_q  <= '0;
            for (int b = 0; b < NB; b++) begin
                st_q[b]  <= S_IDLE;
                cnt_q[b] <= '0;
                gap_q[b] <= 16'd0;
                err_q[b] <= '0;
            end
        end else if (start_ok_s) begin
            mode_q       <= mode_rnd;
            slow_q       <= slow;
            first_vld_q  <= 1'b0;
            proto_q      <= 1'b0;
            done_q       <= 1'b0;
            first_addr_q <= '0;
            first_ba_q   <= 2'd0;
            first_data_q <= '0;
            first_ref_q  <= '0;
            bad_q        <= '0;
            rd_q         <= {NB{LVBL}};
            for (int b = 0; b < NB; b++) begin
                st_q[b]  <= S_REQ;
                cnt_q[b] <= '0;
                gap_q[b] <= 16'd0;
                err_q[b] <= '0;
            end
        end else begin
            done_q  <= &fin_s;
            proto_q <= proto_q | proto_s;
            // Descending order so the lowest mismatching bank is the one captured
            for (int b = NB-1; b >= 0; b--) begin
                if (mis_s[b]) begin
                    bad_q[b] <= 1'b1;
                    if (err_q[b] != {CW{1'b1}}) begin
                        err_q[b] <= err_q[b] + CW'(1);
                    end
                    if (!first_vld_q) begin
                        first_vld_q  <= 1'b1;
                        first_addr_q <= addr_s[b];
                        first_ba_q   <= 2'(b);
                        first_data_q <= data_read;
                        first_ref_q  <= ref_s[b];
                    end
                end
                if (rdy_ok_s[b]) begin
                    if (&cnt_q[b]) begin
                        st_q[b] <= S_DONE;
                        rd_q[b] <= 1'b0;
                    end else begin
                        cnt_q[b] <= cnt_q[b] + AW'(1);
                        if (slow_q && (GAP > 0)) begin
                            st_q[b]  <= S_GAP;
                            gap_q[b] <= 16'd0;
                            rd_q[b]  <= 1'b0;
                        end else begin
                            st_q[b] <= S_REQ;
                            rd_q[b] <= LVBL;
                        end
                    end
                end else begin
                    case (st_q[b])
                        S_REQ: begin
                            if (ba_ack[b]) begin
                                st_q[b] <= S_WAIT;
                                rd_q[b] <= 1'b0;
                            end else if (LVBL) begin
                                rd_q[b] <= 1'b1;
                            end
                        end
                        S_GAP: begin
                            if (gap_q[b] == 16'(GAP-1)) begin
                                st_q[b] <= S_REQ;
                                rd_q[b] <= LVBL;
                            end else begin
                                gap_q[b] <= gap_q[b] + 16'd1;
                            end
                        end
                        default: begin
                        end
                    endcase
                end
            end
        end
    end

    // Pack per-bank address and error count buses
    always_comb begin
        ba_addr = '0;
        err_cnt = '0;
        for (int b = 0; b < NB; b++) begin
            ba_addr[b*AW +: AW] = addr_s[b];
            err_cnt[b*CW +: CW] = err_q[b];
        end
    end

    assign ba_rd      = rd_q;
    assign busy       = |busy_s;
    assign done       = done_q;
    assign bad        = |bad_q;
    assign ba_bad     = bad_q;
    assign first_addr = first_addr_q;
    assign first_ba   = first_ba_q;
    assign first_data = first_data_q;
    assign first_ref  = first_ref_q;
    assign proto_err  = proto_q;

endmodule
